// File: rtl/bram_test_pkg.sv
// Shared types and pattern generation for the BRAM pattern tester.
// Patterns are produced 64 bits wide; callers truncate to their word width.
package bram_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PAT_INC  = 2'd0,
        PAT_ADDR = 2'd1,
        PAT_INV  = 2'd2,
        PAT_LFSR = 2'd3
    } pat_mode_t;

    // Low bits are populated so narrow words still get a useful sequence.
    localparam logic [63:0] LFSR_POLY = 64'hD800_0000_A300_00C3;

    function automatic logic [63:0] pattern_word(
        input pat_mode_t   mode,
        input logic [63:0] base,
        input logic [63:0] addr,
        input logic [63:0] lfsr
    );
        logic [63:0] w;
        case (mode)
            PAT_INC:  w = base + addr;
            PAT_ADDR: w = addr;
            PAT_INV:  w = ~addr;
            default:  w = lfsr;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bram_pattern_tester_debouncer.sv
// Two-flop button synchroniser with a stability counter.
// Emits the debounced level and a one-cycle pulse on its rising edge.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          synced;
    logic          settle;

    assign synced = sync_q[1];
    assign settle = (synced != level) && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], button};
            rise   <= settle && synced;
            // Any cycle agreeing with the accepted level restarts the count.
            if (synced == level || settle)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            if (settle)
                level <= synced;
        end
    end

endmodule

// File: rtl/bram_pattern_tester.sv
// Button-launched BRAM write sweep followed by a compare read-back sweep.
// Reports pass, saturating mismatch count and first failing address.
module bram_pattern_tester
    import bram_test_pkg::*;
#(
    parameter int          DATA_WIDTH      = 32,
    parameter int          ADDR_WIDTH      = 10,
    parameter int          DEPTH           = 1024,
    parameter int          READ_LATENCY    = 1,
    parameter int          DEBOUNCE_CYCLES = 100000,
    parameter logic [63:0] LFSR_SEED       = 64'h1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_button,
    input  logic [1:0]            i_mode,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_din,
    output logic                  o_bram_we,
    output logic                  o_bram_en,
    input  logic [DATA_WIDTH-1:0] i_bram_dout,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ADDR_WIDTH:0]   o_err_count,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int RL = READ_LATENCY;
    localparam logic [CW-1:0] LAST_ADDR  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(RL - 1);
    localparam logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(LFSR_SEED);
    localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(LFSR_POLY);

    logic [1:0] rst_sync;
    logic       rst_n;

    // Reset asserts immediately, releases two clocks later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic btn_level;
    logic btn_rise;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (i_clk),
        .rst_n (rst_n),
        .button(i_button),
        .level (btn_level),
        .rise  (btn_rise)
    );

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    pat_mode_t             mode_q;
    logic [DATA_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] lfsr_q;
    logic [DATA_WIDTH-1:0] lfsr_next;
    logic [DATA_WIDTH-1:0] word;
    logic                  start;
    logic                  last_addr;
    logic                  last_drain;
    logic                  bram_en, bram_we, busy, done;

    assign start      = (state_q == IDLE) && btn_rise && btn_level;
    assign last_addr  = (cnt_q == LAST_ADDR);
    assign last_drain = (cnt_q == LAST_DRAIN);
    assign lfsr_next  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    assign word = DATA_WIDTH'(pattern_word(mode_q, 64'(base_q),
                                           64'(cnt_q), 64'(lfsr_q)));

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        bram_en = 1'b0;
        bram_we = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = WRITE;
            end
            WRITE: begin
                bram_en = 1'b1;
                bram_we = 1'b1;
                if (last_addr) state_d = READ;
            end
            READ: begin
                bram_en = 1'b1;
                if (last_addr) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_drain) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= PAT_INC;
            base_q <= '0;
            lfsr_q <= SEED;
        end else begin
            // Sweep/drain counter restarts on every state change.
            if (state_q == IDLE || state_d != state_q)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            if (start)
                mode_q <= pat_mode_t'(i_mode);
            if (state_q == DONE)
                base_q <= base_q + 1'b1;
            if (start || (state_q == WRITE && last_addr))
                lfsr_q <= SEED;
            else if (state_q == WRITE || state_q == READ)
                lfsr_q <= lfsr_next;
        end
    end

    logic [RL-1:0]         tag_v;
    logic [DATA_WIDTH-1:0] tag_exp  [RL];
    logic [ADDR_WIDTH-1:0] tag_addr [RL];
    logic                  mismatch;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i < RL; i++) begin
                tag_exp[i]  <= '0;
                tag_addr[i] <= '0;
            end
        end else begin
            tag_v[0]    <= (state_q == READ);
            tag_exp[0]  <= word;
            tag_addr[0] <= cnt_q[ADDR_WIDTH-1:0];
            for (int i = 1; i < RL; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_exp[i]  <= tag_exp[i-1];
                tag_addr[i] <= tag_addr[i-1];
            end
        end
    end

    assign mismatch = tag_v[RL-1] && (i_bram_dout != tag_exp[RL-1]);

    logic [ADDR_WIDTH:0]   err_q;
    logic [ADDR_WIDTH-1:0] first_q;
    logic                  pass_q;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else if (start) begin
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            if (mismatch) begin
                if (err_q == '0)
                    first_q <= tag_addr[RL-1];
                if (err_q != '1)
                    err_q <= err_q + 1'b1;
            end
            // Final compare lands on the last drain cycle; fold it in.
            if (state_q == DRAIN && last_drain)
                pass_q <= (err_q == '0) && !mismatch;
        end
    end

    assign o_bram_en        = bram_en;
    assign o_bram_we        = bram_we;
    assign o_bram_addr      = bram_en ? cnt_q[ADDR_WIDTH-1:0] : '0;
    assign o_bram_din       = bram_we ? word : '0;
    assign o_busy           = busy;
    assign o_done           = done;
    assign o_pass           = pass_q;
    assign o_err_count      = err_q;
    assign o_first_err_addr = first_q;

endmodule

// File: tb/tb_bram_pattern_tester.sv
// Bench for bram_pattern_tester: two DUTs (read latency 1 and 3)
// share button/mode and each drive their own ideal BRAM model.
module tb_bram_pattern_tester;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam logic [63:0] SEED64 = 64'hACE1;
    localparam logic [31:0] SEED = 32'hACE1;
    localparam logic [31:0] POLY = 32'(bram_test_pkg::LFSR_POLY);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic button = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [15:0] corrupt = 16'h0;

    logic [AW-1:0] a1, a3, f1, f3;
    logic [DW-1:0] din1, din3, dout1, dout3;
    logic we1, we3, en1, en3, busy1, busy3;
    logic done1, done3, pass1, pass3;
    logic [AW:0] err1, err3;

    always #5 clk = ~clk;

    bram_pattern_tester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(1), .DEBOUNCE_CYCLES(4), .LFSR_SEED(SEED64)
    ) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_button(button), .i_mode(mode),
        .o_bram_addr(a1), .o_bram_din(din1), .o_bram_we(we1),
        .o_bram_en(en1), .i_bram_dout(dout1), .o_busy(busy1),
        .o_done(done1), .o_pass(pass1), .o_err_count(err1),
        .o_first_err_addr(f1)
    );

    bram_pattern_tester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(3), .DEBOUNCE_CYCLES(4), .LFSR_SEED(SEED64)
    ) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_button(button), .i_mode(mode),
        .o_bram_addr(a3), .o_bram_din(din3), .o_bram_we(we3),
        .o_bram_en(en3), .i_bram_dout(dout3), .o_busy(busy3),
        .o_done(done3), .o_pass(pass3), .o_err_count(err3),
        .o_first_err_addr(f3)
    );

    // Ideal BRAMs; bit 3 of flagged words is flipped on read.
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem3 [DEPTH];
    logic [DW-1:0] pipe1;
    logic [DW-1:0] pipe3 [3];

    always @(posedge clk) begin
        if (en1 && we1) mem1[a1] <= din1;
        pipe1 <= (en1 && !we1) ? (mem1[a1] ^ (corrupt[a1] ? 32'h8 : 32'h0)) : '0;
        if (en3 && we3) mem3[a3] <= din3;
        pipe3[0] <= (en3 && !we3) ? (mem3[a3] ^ (corrupt[a3] ? 32'h8 : 32'h0)) : '0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign dout1 = pipe1;
    assign dout3 = pipe3[2];

    int errors = 0;
    int checks = 0;
    int bc1, bc3, dn1, dn3, wc1, wc3;
    int base_ref = 0;
    logic [DW-1:0] wr1 [DEPTH];
    logic [DW-1:0] wr3 [DEPTH];

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] cor;
        bit          pass;
        int          err;
        int          first;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (busy1) bc1++;
        if (busy3) bc3++;
        if (done1) dn1++;
        if (done3) dn3++;
        if (en1 && we1) begin wr1[a1] = din1; wc1++; end
        if (en3 && we3) begin wr3[a3] = din3; wc3++; end
    endtask

    task automatic clear_mon();
        bc1 = 0; bc3 = 0; dn1 = 0; dn3 = 0; wc1 = 0; wc3 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wr1[i] = '0;
            wr3[i] = '0;
        end
    endtask

    task automatic press();
        button = 1'b1;
        repeat (8) tick();
        button = 1'b0;
    endtask

    // Pattern rules stated directly: counter, address, inverse, LFSR walk.
    function automatic logic [31:0] exp_word(input logic [1:0] m, input int b, input int a);
        logic [31:0] l;
        l = SEED;
        case (m)
            2'd0: return 32'(b + a);
            2'd1: return 32'(a);
            2'd2: return ~32'(a);
            default: begin
                for (int i = 0; i < a; i++)
                    l = l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
                return l;
            end
        endcase
    endfunction

    task automatic run(input string nm, input logic [1:0] m, input logic [15:0] cor,
                       input bit ep, input int ee, input int ef);
        int t;
        int bad1, bad3;
        mode = m;
        corrupt = cor;
        clear_mon();
        press();
        t = 0;
        while ((dn1 == 0 || dn3 == 0) && t < 300) begin
            tick();
            t++;
        end
        if (dn1 == 0 || dn3 == 0) chk({nm, "_timeout"}, 0, 1);
        repeat (3) tick();
        bad1 = 0;
        bad3 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr1[i] != exp_word(m, base_ref, i)) bad1++;
            if (wr3[i] != exp_word(m, base_ref, i)) bad3++;
        end
        chk({nm, "_len1"}, bc1, 2 * DEPTH + 1 + 1);
        chk({nm, "_len3"}, bc3, 2 * DEPTH + 3 + 1);
        chk({nm, "_done1"}, dn1, 1);
        chk({nm, "_done3"}, dn3, 1);
        chk({nm, "_wcnt1"}, wc1, DEPTH);
        chk({nm, "_wcnt3"}, wc3, DEPTH);
        chk({nm, "_wdata1"}, bad1, 0);
        chk({nm, "_wdata3"}, bad3, 0);
        chk({nm, "_pass1"}, pass1, ep);
        chk({nm, "_pass3"}, pass3, ep);
        chk({nm, "_err1"}, err1, ee);
        chk({nm, "_err3"}, err3, ee);
        chk({nm, "_first1"}, f1, ef);
        chk({nm, "_first3"}, f3, ef);
        base_ref++;
    endtask

    function automatic longint outs1();
        return longint'({a1, din1, we1, en1, busy1, done1, pass1, err1, f1});
    endfunction

    function automatic longint outs3();
        return longint'({a3, din3, we3, en3, busy3, done3, pass3, err3, f3});
    endfunction

    initial begin
        int t, ne, nf;
        logic [1:0] rm;
        logic [15:0] rc;

        tbl[0] = '{2'd0, 16'h0000, 1'b1, 0, 0};
        tbl[1] = '{2'd0, 16'h0000, 1'b1, 0, 0};
        tbl[2] = '{2'd1, 16'h0000, 1'b1, 0, 0};
        tbl[3] = '{2'd2, 16'h0220, 1'b0, 2, 5};
        tbl[4] = '{2'd3, 16'h0000, 1'b1, 0, 0};
        tbl[5] = '{2'd3, 16'h8001, 1'b0, 2, 0};
        tbl[6] = '{2'd2, 16'h8000, 1'b0, 1, 15};

        clear_mon();
        repeat (3) tick();
        chk("reset_outs1", outs1(), 0);
        chk("reset_outs3", outs3(), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_outs1", outs1(), 0);

        for (int i = 0; i < 7; i++)
            run($sformatf("vec%0d", i), tbl[i].mode, tbl[i].cor,
                tbl[i].pass, tbl[i].err, tbl[i].first);

        // Two-cycle bounces never satisfy the stability window.
        clear_mon();
        repeat (5) begin
            button = 1'b1;
            repeat (2) tick();
            button = 1'b0;
            repeat (2) tick();
        end
        repeat (20) tick();
        chk("bounce_busy1", bc1, 0);
        chk("bounce_busy3", bc3, 0);

        // Second press lands mid-run and must be dropped.
        mode = 2'd1;
        corrupt = 16'h0;
        clear_mon();
        press();
        t = 0;
        while (bc1 < 6 && t < 100) begin tick(); t++; end
        press();
        repeat (80) tick();
        chk("busy_press_done1", dn1, 1);
        chk("busy_press_done3", dn3, 1);
        chk("busy_press_pass1", pass1, 1);
        base_ref++;

        // Abort in the tenth write cycle.
        mode = 2'd0;
        clear_mon();
        press();
        t = 0;
        while (bc1 < 10 && t < 100) begin tick(); t++; end
        chk("abort_in_write", we1, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs1", outs1(), 0);
        chk("abort_outs3", outs3(), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        base_ref = 0;
        run("after_abort", 2'd0, 16'h0, 1'b1, 0, 0);

        for (int r = 0; r < 6; r++) begin
            rm = 2'($urandom_range(0, 3));
            rc = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 2) == 0) rc = 16'h0;
            ne = 0;
            nf = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (rc[i]) begin
                    ne++;
                    if (nf < 0) nf = i;
                end
            end
            if (nf < 0) nf = 0;
            run($sformatf("rand%0d", r), rm, rc, ne == 0, ne, nf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
